// File: rtl/ir_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// ir_cmd_ctrl
//
// Turns the stream of decoded IR frames into key events. A command is only
// reported as a press after CONFIRM_N identical frames. While the key stays
// held, a repeat event is produced every REPEAT_EVERY frames. A release is
// produced when a different command arrives, or when no accepted frame
// arrives for TIMEOUT cycles. Events are queued in a 4-deep
// first-word-fall-through FIFO.
//
// Parameters:
//   ADDR         accepted device address (frame[4:0])
//   ADDR_ANY     1 = accept frames with any address
//   CONFIRM_N    identical frames needed before a press (1..7)
//   REPEAT_EVERY held frames per repeat event (1..15)
//   TIMEOUT      idle cycles after the last accepted frame that mean release
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   frame        received code: command = frame[11:5], address = frame[4:0]
//   frame_rdy    level valid flag from the decoder; one frame per 0->1 edge
//   evt_valid    an event is at the FIFO head
//   evt_ready    consumer accepts the head event
//   evt_cmd      command of the head event
//   evt_type     01 = press, 10 = repeat, 11 = release
//   held         the controller considers a key held
//   overflow     sticky, set when an event was dropped on a full FIFO
//   ovf_clr      clears overflow (a new drop in the same cycle wins)
// ---------------------------------------------------------------------------
module ir_cmd_ctrl #(
  parameter logic [4:0] ADDR         = 5'd1,
  parameter bit         ADDR_ANY     = 1'b0,
  parameter int         CONFIRM_N    = 2,
  parameter int         REPEAT_EVERY = 4,
  parameter int         TIMEOUT      = 3000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] frame,
  input  logic        frame_rdy,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [6:0]  evt_cmd,
  output logic [1:0]  evt_type,
  output logic        held,
  output logic        overflow,
  input  logic        ovf_clr
);

  localparam int              TW          = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TMR_RELOAD  = TW'(TIMEOUT);
  localparam logic [2:0]      CONFIRM_LIM = 3'(CONFIRM_N);
  localparam logic [3:0]      REPEAT_LIM  = 4'(REPEAT_EVERY);
  localparam logic [1:0]      EVT_PRESS   = 2'b01;
  localparam logic [1:0]      EVT_REPEAT  = 2'b10;
  localparam logic [1:0]      EVT_RELEASE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // Input capture
  logic        rdy_q, rdy_d;
  logic        rdy_dly_q, rdy_dly_d;
  logic [11:0] frame_q, frame_d;

  // Controller state
  state_t          state_q, state_d;
  logic [6:0]      cur_cmd_q, cur_cmd_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [3:0]      rep_q, rep_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            pend_q, pend_d;

  // Event FIFO
  logic [8:0]      mem_q [4];
  logic [8:0]      mem_d [4];
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  logic            ovf_q, ovf_d;

  // Internal handshakes
  logic            frame_new;
  logic            frm_ok;
  logic            same_cmd;
  logic [6:0]      frm_cmd;
  logic            push_vld;
  logic [8:0]      push_data;
  logic            push_ok;
  logic            pop;
  logic            full;
  logic [8:0]      head;

  // frame_rdy is a level, so a frame is recognised only on the rising edge
  // of the registered copy; frame is registered alongside so the data seen
  // at the edge belongs to that frame.
  always_comb begin
    rdy_d     = frame_rdy;
    rdy_dly_d = rdy_q;
    frame_d   = frame;
  end

  always_comb begin
    frame_new = rdy_q & ~rdy_dly_q;
    frm_cmd   = frame_q[11:5];
    frm_ok    = frame_new & (ADDR_ANY | (frame_q[4:0] == ADDR));
    same_cmd  = (frm_cmd == cur_cmd_q);
  end

  // Next-state logic of the press/repeat/release controller. An accepted
  // frame takes priority over timer expiry. When a new command replaces a
  // held one and CONFIRM_N is 1, the release goes out this cycle and the
  // press of the new command is deferred one cycle via pend.
  always_comb begin
    state_d   = state_q;
    cur_cmd_d = cur_cmd_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    tmr_d     = tmr_q;
    pend_d    = 1'b0;
    push_vld  = 1'b0;
    push_data = 9'd0;

    if ((state_q != ST_IDLE) && (tmr_q != '0)) begin
      tmr_d = tmr_q - 1'b1;
    end

    if (pend_q) begin
      push_vld  = 1'b1;
      push_data = {EVT_PRESS, cur_cmd_q};
    end else if (frm_ok) begin
      tmr_d = TMR_RELOAD;
      case (state_q)
        ST_IDLE: begin
          cur_cmd_d = frm_cmd;
          cnt_d     = 3'd1;
          if (CONFIRM_N == 1) begin
            push_vld  = 1'b1;
            push_data = {EVT_PRESS, frm_cmd};
            rep_d     = 4'd0;
            state_d   = ST_HELD;
          end else begin
            state_d   = ST_CONFIRM;
          end
        end
        ST_CONFIRM: begin
          if (same_cmd) begin
            cnt_d = cnt_q + 3'd1;
            if ((cnt_q + 3'd1) == CONFIRM_LIM) begin
              push_vld  = 1'b1;
              push_data = {EVT_PRESS, cur_cmd_q};
              rep_d     = 4'd0;
              state_d   = ST_HELD;
            end
          end else begin
            cur_cmd_d = frm_cmd;
            cnt_d     = 3'd1;
          end
        end
        ST_HELD: begin
          if (same_cmd) begin
            if ((rep_q + 4'd1) == REPEAT_LIM) begin
              push_vld  = 1'b1;
              push_data = {EVT_REPEAT, cur_cmd_q};
              rep_d     = 4'd0;
            end else begin
              rep_d     = rep_q + 4'd1;
            end
          end else begin
            push_vld  = 1'b1;
            push_data = {EVT_RELEASE, cur_cmd_q};
            cur_cmd_d = frm_cmd;
            cnt_d     = 3'd1;
            rep_d     = 4'd0;
            if (CONFIRM_N == 1) begin
              pend_d  = 1'b1;
              state_d = ST_HELD;
            end else begin
              state_d = ST_CONFIRM;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if ((state_q != ST_IDLE) && (tmr_q == '0)) begin
      if (state_q == ST_HELD) begin
        push_vld  = 1'b1;
        push_data = {EVT_RELEASE, cur_cmd_q};
      end
      cnt_d   = 3'd0;
      rep_d   = 4'd0;
      state_d = ST_IDLE;
    end
  end

  // FIFO bookkeeping. A push into a full FIFO is still accepted when the
  // head is popped in the same cycle; otherwise it is dropped and recorded
  // in the sticky overflow flag.
  always_comb begin
    full     = (count_q == 3'd4);
    pop      = evt_valid & evt_ready;
    push_ok  = push_vld & (~full | pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !push_ok) begin
      count_d = count_q - 3'd1;
    end

    if (push_vld && !push_ok) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Head of the FIFO is presented directly; outputs read as zero when empty.
  always_comb begin
    head      = mem_q[rd_ptr_q];
    evt_valid = (count_q != 3'd0);
    evt_type  = evt_valid ? head[8:7] : 2'b00;
    evt_cmd   = evt_valid ? head[6:0] : 7'd0;
    held      = (state_q == ST_HELD);
    overflow  = ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q     <= 1'b0;
      rdy_dly_q <= 1'b0;
      frame_q   <= 12'd0;
      state_q   <= ST_IDLE;
      cur_cmd_q <= 7'd0;
      cnt_q     <= 3'd0;
      rep_q     <= 4'd0;
      tmr_q     <= '0;
      pend_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 9'd0;
      end
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      ovf_q     <= 1'b0;
    end else begin
      rdy_q     <= rdy_d;
      rdy_dly_q <= rdy_dly_d;
      frame_q   <= frame_d;
      state_q   <= state_d;
      cur_cmd_q <= cur_cmd_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      tmr_q     <= tmr_d;
      pend_q    <= pend_d;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ir_cmd_ctrl
//
// Two controllers share one frame source: dut0 uses the default filtering
// (CONFIRM_N=2, address 1 only), dut1 confirms on the first frame and
// accepts any address. Directed scenarios exercise dut0; a randomized
// phase then compares both against an event-level reference model.
// ---------------------------------------------------------------------------
module tb_ir_cmd_ctrl;

  localparam int TMO       = 60;
  localparam int LONG_IDLE = TMO + 30;
  localparam logic [1:0] PRESS   = 2'b01;
  localparam logic [1:0] REPEAT  = 2'b10;
  localparam logic [1:0] RELEASE = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] frame;
  logic        frame_rdy;
  logic        evt_ready;
  logic        ovf_clr;

  logic        v0, h0, o0, v1, h1, o1;
  logic [6:0]  c0, c1;
  logic [1:0]  t0, t1;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state per instance: 0 idle, 1 confirming, 2 held
  int         m_state [2];
  logic [6:0] m_cmd   [2];
  int         m_cnt   [2];
  int         m_rep   [2];
  int         m_el    [2];
  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];
  bit         mon_en = 1'b0;

  // Free-running clock
  always #5 clk = ~clk;

  ir_cmd_ctrl #(
    .ADDR(5'd1), .ADDR_ANY(1'b0), .CONFIRM_N(2), .REPEAT_EVERY(4), .TIMEOUT(TMO)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .frame(frame), .frame_rdy(frame_rdy),
    .evt_valid(v0), .evt_ready(evt_ready), .evt_cmd(c0), .evt_type(t0),
    .held(h0), .overflow(o0), .ovf_clr(ovf_clr)
  );

  ir_cmd_ctrl #(
    .ADDR(5'd1), .ADDR_ANY(1'b1), .CONFIRM_N(1), .REPEAT_EVERY(4), .TIMEOUT(TMO)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .frame(frame), .frame_rdy(frame_rdy),
    .evt_valid(v1), .evt_ready(evt_ready), .evt_cmd(c1), .evt_type(t1),
    .held(h1), .overflow(o1), .ovf_clr(ovf_clr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: valid level for 3 cycles, then 3 quiet cycles
  task automatic applyStimulus(input logic [11:0] f);
    frame     = f;
    frame_rdy = 1'b1;
    waitCycles(3);
    frame_rdy = 1'b0;
    waitCycles(3);
  endtask

  task automatic popEvent(input string tag, input logic [8:0] e);
    checkOutput(tag, {v0, t0, c0}, {1'b1, e});
    evt_ready = 1'b1;
    waitCycles(1);
    evt_ready = 1'b0;
  endtask

  task automatic expectEvt(input int i, input logic [8:0] e);
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Key-level behaviour of one controller for an incoming frame
  task automatic modelFrame(input int i, input logic [11:0] f);
    logic [6:0] c;
    int         cn;
    c  = f[11:5];
    cn = (i == 0) ? 2 : 1;
    if (i == 0 && f[4:0] != 5'd1) return;
    m_el[i] = 0;
    if (m_state[i] == 0) begin
      m_cmd[i] = c;
      m_cnt[i] = 1;
      if (cn == 1) begin
        expectEvt(i, {PRESS, c});
        m_rep[i]   = 0;
        m_state[i] = 2;
      end else begin
        m_state[i] = 1;
      end
    end else if (m_state[i] == 1) begin
      if (c == m_cmd[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == cn) begin
          expectEvt(i, {PRESS, c});
          m_rep[i]   = 0;
          m_state[i] = 2;
        end
      end else begin
        m_cmd[i] = c;
        m_cnt[i] = 1;
      end
    end else begin
      if (c == m_cmd[i]) begin
        m_rep[i]++;
        if (m_rep[i] == 4) begin
          expectEvt(i, {REPEAT, c});
          m_rep[i] = 0;
        end
      end else begin
        expectEvt(i, {RELEASE, m_cmd[i]});
        m_cmd[i] = c;
        m_cnt[i] = 1;
        m_rep[i] = 0;
        if (cn == 1) begin
          expectEvt(i, {PRESS, c});
          m_state[i] = 2;
        end else begin
          m_state[i] = 1;
        end
      end
    end
  endtask

  // A long silence ends any key: release if held, nothing if confirming
  task automatic modelIdle();
    for (int i = 0; i < 2; i++) begin
      if (m_state[i] == 2) expectEvt(i, {RELEASE, m_cmd[i]});
      m_state[i] = 0;
      m_el[i]    = 0;
    end
    waitCycles(LONG_IDLE);
    checkOutput("idle_held0", h0, 1'b0);
    checkOutput("idle_held1", h1, 1'b0);
  endtask

  // Scoreboard: every event the consumer takes must match the model
  always @(negedge clk) begin
    if (mon_en && evt_ready) begin
      if (v0) begin
        if (exp_q0.size() == 0) checkOutput("spurious0", {t0, c0}, 9'h000);
        else                    checkOutput("evt0", {t0, c0}, exp_q0.pop_front());
      end
      if (v1) begin
        if (exp_q1.size() == 0) checkOutput("spurious1", {t1, c1}, 9'h000);
        else                    checkOutput("evt1", {t1, c1}, exp_q1.pop_front());
      end
    end
  end

  initial begin
    logic [6:0]  last_cmd;
    logic [6:0]  c;
    logic [4:0]  a;
    int          r;
    bit          need_idle;

    rst_n     = 1'b0;
    frame     = 12'd0;
    frame_rdy = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    waitCycles(3);

    // Reset state
    checkOutput("rst_valid", v0, 1'b0);
    checkOutput("rst_held", h0, 1'b0);
    checkOutput("rst_ovf", o0, 1'b0);
    checkOutput("rst_cmd", c0, 7'd0);
    checkOutput("rst_type", t0, 2'd0);
    checkOutput("rst_valid1", v1, 1'b0);
    rst_n = 1'b1;
    waitCycles(2);

    // First frame alone gives nothing; the second confirms a press of 5
    applyStimulus(12'h0A1);
    checkOutput("first_valid", v0, 1'b0);
    checkOutput("first_held", h0, 1'b0);
    applyStimulus(12'h0A1);
    checkOutput("press_held", h0, 1'b1);
    popEvent("press5", {PRESS, 7'd5});

    // Eight held frames give two repeats, silence gives a release
    repeat (8) applyStimulus(12'h0A1);
    waitCycles(LONG_IDLE);
    checkOutput("timeout_held", h0, 1'b0);
    popEvent("repeat5a", {REPEAT, 7'd5});
    popEvent("repeat5b", {REPEAT, 7'd5});
    popEvent("release5", {RELEASE, 7'd5});
    checkOutput("drained", v0, 1'b0);

    // Foreign address is ignored entirely
    applyStimulus(12'h0A2);
    checkOutput("addr_valid", v0, 1'b0);
    checkOutput("addr_held", h0, 1'b0);

    // A long valid level is a single frame
    frame     = 12'h0A1;
    frame_rdy = 1'b1;
    waitCycles(1000);
    frame_rdy = 1'b0;
    waitCycles(3);
    checkOutput("level_valid", v0, 1'b0);
    checkOutput("level_held", h0, 1'b0);

    // Switching command while held: release of old, then press of new
    applyStimulus(12'h0A1);
    applyStimulus(12'h0A1);
    popEvent("press5_sw", {PRESS, 7'd5});
    applyStimulus(12'h0C1);
    checkOutput("swap_confirm_held", h0, 1'b0);
    applyStimulus(12'h0C1);
    checkOutput("swap_held", h0, 1'b1);
    popEvent("release5_sw", {RELEASE, 7'd5});
    popEvent("press6_sw", {PRESS, 7'd6});
    waitCycles(LONG_IDLE);
    popEvent("release6_sw", {RELEASE, 7'd6});

    // Fill the FIFO with four events, the fifth is dropped
    repeat (10) applyStimulus(12'h0A1);
    waitCycles(LONG_IDLE);
    checkOutput("full_no_ovf", o0, 1'b0);
    checkOutput("stable_head", {t0, c0}, {PRESS, 7'd5});
    applyStimulus(12'h0C1);
    applyStimulus(12'h0C1);
    checkOutput("ovf_set", o0, 1'b1);
    popEvent("ovf_ev1", {PRESS, 7'd5});
    popEvent("ovf_ev2", {REPEAT, 7'd5});
    popEvent("ovf_ev3", {REPEAT, 7'd5});
    popEvent("ovf_ev4", {RELEASE, 7'd5});
    checkOutput("ovf_dropped", v0, 1'b0);
    checkOutput("ovf_sticky", o0, 1'b1);
    ovf_clr = 1'b1;
    waitCycles(1);
    ovf_clr = 1'b0;
    checkOutput("ovf_cleared", o0, 1'b0);
    waitCycles(LONG_IDLE);
    popEvent("release6_ovf", {RELEASE, 7'd6});

    // Reset while held with two events queued
    repeat (6) applyStimulus(12'h0A1);
    checkOutput("pre_rst_held", h0, 1'b1);
    checkOutput("pre_rst_valid", v0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", v0, 1'b0);
    checkOutput("mid_rst_held", h0, 1'b0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(LONG_IDLE);
    checkOutput("post_rst_no_release", v0, 1'b0);
    applyStimulus(12'h0A1);
    checkOutput("post_rst_new_held", h0, 1'b0);
    checkOutput("post_rst_new_valid", v0, 1'b0);
    applyStimulus(12'h0A1);
    popEvent("post_rst_press", {PRESS, 7'd5});
    waitCycles(LONG_IDLE);
    popEvent("post_rst_release", {RELEASE, 7'd5});

    // Randomized phase against the reference model
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(2);
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0;
      m_cmd[i]   = 7'd0;
      m_cnt[i]   = 0;
      m_rep[i]   = 0;
      m_el[i]    = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
    last_cmd  = 7'd5;
    evt_ready = 1'b1;
    mon_en    = 1'b1;

    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 99);
      need_idle = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (m_state[i] != 0 && m_el[i] + 12 >= TMO - 4) need_idle = 1'b1;
      end
      if (r < 6 || need_idle) begin
        modelIdle();
      end else begin
        c = ($urandom_range(0, 9) < 6) ? last_cmd : 7'($urandom_range(4, 6));
        a = ($urandom_range(0, 9) < 2) ? 5'd2 : 5'd1;
        last_cmd = c;
        for (int i = 0; i < 2; i++) modelFrame(i, {c, a});
        applyStimulus({c, a});
        for (int i = 0; i < 2; i++) m_el[i] += 6;
        checkOutput("rand_held0", h0, (m_state[0] == 2));
        checkOutput("rand_held1", h1, (m_state[1] == 2));
      end
    end
    modelIdle();
    waitCycles(10);
    mon_en = 1'b0;
    checkOutput("leftover0", exp_q0.size(), 0);
    checkOutput("leftover1", exp_q1.size(), 0);
    checkOutput("rand_ovf0", o0, 1'b0);
    checkOutput("rand_ovf1", o1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ir_cmd_ctrl.md
IR_CMD_CTRL -- requirements
Module: ir_cmd_ctrl

Interface
REQ-001 SHALL have parameter ADDR, default 5'd1: accepted device address.
REQ-002 SHALL have parameter ADDR_ANY, default 0: when 1, the address filter is disabled.
REQ-003 SHALL have parameter CONFIRM_N, default 2, range 1-7: identical frames required before a press is reported.
REQ-004 SHALL have parameter REPEAT_EVERY, default 4, range 1-15: held frames per repeat event.
REQ-005 SHALL have parameter TIMEOUT, default 3000000: idle cycles after the last frame that signal release (about 60 ms).
REQ-006 SHALL have the port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-007 SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have the port frame, input, 12 bits: received code; command = frame[11:5], address = frame[4:0].
REQ-009 SHALL have the port frame_rdy, input, 1 bit: level valid flag from the IR decoder; it may stay high for many cycles.
REQ-010 SHALL have the port evt_valid, output, 1 bit: an event is available at the FIFO head.
REQ-011 SHALL have the port evt_ready, input, 1 bit: the consumer accepts the head event.
REQ-012 SHALL have the port evt_cmd, output, 7 bits: command of the head event.
REQ-013 SHALL have the port evt_type, output, 2 bits: 01 = press, 10 = repeat, 11 = release.
REQ-014 SHALL have the port held, output, 1 bit: the state machine is in HELD.
REQ-015 SHALL have the port overflow, output, 1 bit: sticky flag, set when an event is dropped.
REQ-016 SHALL have the port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-017 SHALL detect a new frame only on a 0->1 transition of registered frame_rdy; a level held high SHALL count as one frame.
REQ-018 SHALL discard frames with address != ADDR unless ADDR_ANY=1; a discarded frame SHALL NOT reload the timer.
REQ-019 SHALL implement the states IDLE, CONFIRM and HELD, with a 7-bit cur_cmd register, a 3-bit match counter, a 4-bit repeat counter and a timeout counter of width clog2(TIMEOUT+1).
REQ-020 SHALL, in IDLE on an accepted frame: set cur_cmd, set count=1, reload the timer, then go to HELD with a press if CONFIRM_N=1, otherwise go to CONFIRM.
REQ-021 SHALL, in CONFIRM on the same command: increment count and reload the timer; at count==CONFIRM_N it SHALL push a press, clear the repeat counter and go to HELD.
REQ-022 SHALL, in CONFIRM on a different command: restart with the new cur_cmd and count=1; no event SHALL be produced.
REQ-023 SHALL, in HELD on the same command: reload the timer and increment the repeat counter; when it reaches REPEAT_EVERY it SHALL push a repeat and clear the counter.
REQ-024 SHALL, in HELD on a different command: push a release of the old cur_cmd, load the new command with count=1, and go to CONFIRM, or to HELD with a press if CONFIRM_N=1.
REQ-025 SHALL, in the CONFIRM=1 variant of REQ-024, push the press in the next cycle after the release; both SHALL be queued in order.
REQ-026 SHALL decrement the timer every cycle in CONFIRM and HELD.
REQ-027 SHALL, when the timer hits 0, push a release from HELD, or produce no event from CONFIRM, and go to IDLE.
REQ-028 SHALL give an accepted frame priority over expiry when both occur in the same cycle; the timer SHALL reload.
REQ-029 SHALL provide an event FIFO of depth 4, 9 bits wide ({type, cmd}), as first-word-fall-through.
REQ-030 SHALL assert evt_valid while the FIFO is non-empty; an event SHALL be popped on evt_valid && evt_ready.
REQ-031 SHALL make a pushed event visible on evt_valid in the cycle after the push.
REQ-032 SHALL, on a push while full with no pop in the same cycle, drop the new event and set overflow.
REQ-033 SHALL accept a push and a pop in the same cycle when full, with no drop.
REQ-034 SHALL wrap the read and write pointers modulo 4, using a 3-bit occupancy count.
REQ-035 SHALL clear overflow when ovf_clr is high; a set in the same cycle SHALL win.
REQ-036 SHALL keep evt_cmd and evt_type stable while evt_valid && !evt_ready.

Reset
REQ-037 SHALL, with rst_n low, asynchronously bring the state to IDLE, empty the FIFO, and set evt_valid=0, held=0, overflow=0, evt_cmd=0, evt_type=0, all counters to 0 and the registered frame_rdy to 0.
REQ-038 SHALL, on reset mid-HELD, emit no release, and the first frame after rst_n rises SHALL be treated as new.

Verification
REQ-039 Two frames 12'h0A1 (cmd 5, addr 1), then evt_ready=1 -> one press with cmd 5; held=1; no event after the first frame alone.
REQ-040 Eight further 12'h0A1 frames, then silence for TIMEOUT cycles -> two repeats with cmd 5, then a release with cmd 5, held=0.
REQ-041 Frame 12'h0A2 (addr 2), ADDR_ANY=0 -> no event, state stays IDLE.
REQ-042 frame_rdy held high for 1000 cycles with 12'h0A1 -> counted as one frame, no press.
REQ-043 HELD on cmd 5, then two 12'h0C1 frames (cmd 6) -> release of 5, then press of 6, in order.
REQ-044 evt_ready=0 and 5 events generated -> 4 queued, overflow=1, the 4 events drain in order; ovf_clr clears overflow.
REQ-045 rst_n pulsed low mid-HELD with 2 events queued -> evt_valid=0 and held=0 immediately.
